hazard_mdu: RTL and testbench
=============================

// Module: hazard_mdu
// PURPOSE
//   Pipeline hazard unit for the 5-stage core with a multi-cycle multiply/divide unit (MDU) in Execute.
//   - Generates E-stage operand bypass selects.
//   - Detects load-use hazards and takes branch/jump flushes.
//   - Runs a small FSM that holds F/D/E while an MDU op occupies Execute, and inserts bubbles into Memory.
//   - Register-address width and MDU latency are parameters.
// PARAMETERS
//   REG_AW   5   register address width (x0 = all-zero address, never forwarded or hazarded)
//   MDU_LAT  4   Execute-stage occupancy of one MDU op, in cycles; legal range 2..255
//   CNT_W    32  width of the performance counters (HAZARD_PERF_EN only)
// PORTS
//   clk          in   1       core clock, rising edge
//   reset        in   1       synchronous, active-high
//   Rs1E, Rs2E   in   REG_AW  source registers of the instruction in E
//   RdM, RdW     in   REG_AW  destination registers in M / W
//   RegWriteM    in   1       M instruction writes the register file
//   RegWriteW    in   1       W instruction writes the register file
//   Rs1D, Rs2D   in   REG_AW  source registers of the instruction in D
//   RdE          in   REG_AW  destination register in E
//   ResultSrcE0  in   1       instruction in E is a load
//   PCSrcE       in   1       taken branch/jump resolved in E
//   MulStartE    in   1       instruction in E is an MDU op; datapath holds it high while the op sits in E
//   ForwardAE    out  2       operand A select: 00 regfile, 01 W result, 10 M ALU result
//   ForwardBE    out  2       operand B select, same encoding
//   StallF       out  1       hold PC
//   StallD       out  1       hold the F/D register
//   StallE       out  1       hold the D/E register
//   FlushD       out  1       clear the F/D register
//   FlushE       out  1       clear the D/E register
//   FlushM       out  1       clear the E/M register (inserts a bubble)
//   MduBusy      out  1       FSM in BUSY
// BEHAVIOUR
//   Forwarding (combinational), same rule for A and B:
//   - 10 if RegWriteM & RdM!=0 & RdM==RsE.
//   - else 01 if RegWriteW & RdW!=0 & RdW==RsE.
//   - else 00.
//   - M has priority over W.
//   Load-use: lwStall = ResultSrcE0 & RdE!=0 & (Rs1D==RdE | Rs2D==RdE).
//   MDU FSM, states IDLE/BUSY, 8-bit counter cnt:
//   - IDLE & MulStartE & !PCSrcE -> BUSY, cnt<=1.
//   - BUSY & cnt<MDU_LAT-1 -> cnt<=cnt+1.
//   - BUSY & cnt==MDU_LAT-1 -> IDLE, cnt<=0. The op leaves E on this edge.
//   - mduStall = (IDLE & MulStartE & !PCSrcE) | (BUSY & cnt<MDU_LAT-1).
//   - Result: exactly MDU_LAT cycles in E, of which MDU_LAT-1 are stalled.
//   Output equations:
//   - StallF = StallD = lwStall | mduStall.
//   - StallE = FlushM = mduStall.
//   - FlushD = PCSrcE.
//   - FlushE = PCSrcE | (lwStall & !mduStall). The held MDU op in E is never cleared by a load-use.
//   - MduBusy = (state==BUSY).
//   Reset:
//   - State IDLE, cnt 0.
//   - With inputs low, every output is 0.
//   - Reset asserted mid-op aborts to IDLE on the next edge; stalls drop that cycle.
//   Simultaneous events:
//   - PCSrcE and MulStartE are mutually exclusive by datapath construction.
//   - If both are seen in IDLE, PCSrcE wins: no FSM entry.
//   - lwStall during BUSY: stall is held, no E flush; it is re-evaluated after the op leaves.
// CONFIGURATION
//   HAZARD_PERF_EN defined:
//   - Adds output StallCnt[CNT_W], which counts cycles with StallF=1.
//   - Adds output FlushCnt[CNT_W], which counts cycles with FlushD=1.
//   - Both counters saturate at all-ones and clear on reset.
//   HAZARD_PERF_EN undefined:
//   - StallCnt and FlushCnt are absent and no counter logic is generated.
//   - All other behaviour is identical.
// TESTING
//   - Forward priority: Rs1E=5, RdM=5, RdW=5, RegWriteM=RegWriteW=1 -> ForwardAE=10.
//     Same with RdM=0 -> ForwardAE=01. Same with RdW=0 -> ForwardAE=00.
//   - Load-use: ResultSrcE0=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1, StallE=0.
//     Same with RdE=0 -> all 0.
//   - MDU, MDU_LAT=4, MulStartE held 4 cycles -> StallF/StallD/StallE/FlushM = 1,1,1,0 across the 4 cycles.
//     MduBusy = 0,1,1,1. FSM back in IDLE on cycle 5.
//   - MDU with load-use in D: MulStartE=1 while ResultSrcE0=1, RdE=Rs1D=3 on cycle 2 -> FlushE=0 while stalled.
//   - Branch: PCSrcE=1 with MulStartE=0 -> FlushD=FlushE=1, stalls 0.
//     Reset high in cycle 2 of an MDU op -> MduBusy=0 and all stalls 0 next cycle.
//   - HAZARD_PERF_EN, CNT_W=4: 20 consecutive stall cycles -> StallCnt=15 (saturated). Reset -> 0.

Source files
------------

// File: rtl/hazard_mdu.sv
// ---------------------------------------------------------------------------
// hazard_mdu
//   Hazard unit for the 5-stage core with a multi-cycle multiply/divide unit
//   (MDU) in Execute.
//   - Operand bypass selects for the E stage. M has priority over W, and x0
//     is never forwarded.
//   - Load-use detection and branch/jump flushes.
//   - A two-state FSM (IDLE/BUSY) holds F/D/E while an MDU op occupies E.
//     It also pushes bubbles into M. An op stays in E for exactly MDU_LAT
//     cycles, and MDU_LAT-1 of those cycles are stalled.
//
// Configuration macro: HAZARD_PERF_EN
//   When defined, the StallCnt and FlushCnt outputs are added. They are
//   saturating cycle counters for StallF and FlushD.
//
// Parameters
//   REG_AW   register address width
//   MDU_LAT  E-stage occupancy of one MDU op (2..255)
//   CNT_W    performance counter width (HAZARD_PERF_EN only)
//
// Ports
//   clk, reset              rising-edge clock, synchronous active-high reset
//   Rs1E, Rs2E              sources of the instruction in E
//   RdM, RdW, RegWriteM/W   destinations and write enables in M / W
//   Rs1D, Rs2D              sources of the instruction in D
//   RdE, ResultSrcE0        destination of E; E is a load
//   PCSrcE                  taken branch/jump resolved in E
//   MulStartE               E holds an MDU op (held high while it sits in E)
//   ForwardAE, ForwardBE    00 regfile, 01 W result, 10 M ALU result
//   StallF/D/E              hold PC, F/D and D/E registers
//   FlushD/E/M              clear F/D, D/E and E/M registers
//   MduBusy                 FSM is in BUSY
//   StallCnt, FlushCnt      (HAZARD_PERF_EN) saturating counters
// ---------------------------------------------------------------------------
module hazard_mdu #(
  parameter int REG_AW  = 5,
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] RdE,
  input  logic              ResultSrcE0,
  input  logic              PCSrcE,
  input  logic              MulStartE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              MduBusy
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0]  StallCnt,
  output logic [CNT_W-1:0]  FlushCnt
`endif
);

  // Elaboration-time parameter sanity check. The 8-bit cnt bounds MDU_LAT.
  if (MDU_LAT < 2 || MDU_LAT > 255 || CNT_W < 1) begin : g_bad_param
    $error("hazard_mdu: MDU_LAT must be 2..255 and CNT_W >= 1");
  end

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(MDU_LAT - 1);
  localparam logic [REG_AW-1:0] X0 = '0;

  state_t     state;
  logic [7:0] cnt;
  logic       mdu_start;
  logic       mdu_stall;
  logic       lw_stall;

  // Bypass select for one E-stage source. The M result is newer than the
  // W result, so M is checked first.
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
    if (RegWriteM && RdM != X0 && RdM == rs)      return 2'b10;
    else if (RegWriteW && RdW != X0 && RdW == rs) return 2'b01;
    else                                          return 2'b00;
  endfunction

  assign ForwardAE = fwd_sel(Rs1E);
  assign ForwardBE = fwd_sel(Rs2E);

  assign lw_stall = ResultSrcE0 && RdE != X0 && (Rs1D == RdE || Rs2D == RdE);

  // A branch resolving in E kills the would-be MDU op, so no FSM entry occurs.
  assign mdu_start = (state == IDLE) && MulStartE && !PCSrcE;

  // The final BUSY cycle (cnt == LAST_CNT) is not stalled: the op leaves E
  // on that edge while the younger instructions advance behind it.
  assign mdu_stall = mdu_start || (state == BUSY && cnt < LAST_CNT);

  assign StallF  = lw_stall || mdu_stall;
  assign StallD  = lw_stall || mdu_stall;
  assign StallE  = mdu_stall;
  assign FlushM  = mdu_stall;
  assign FlushD  = PCSrcE;
  // A load-use must not clear D/E while the MDU op is being held there.
  assign FlushE  = PCSrcE || (lw_stall && !mdu_stall);
  assign MduBusy = (state == BUSY);

  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples its pre-edge value, whatever the statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (mdu_start) begin
            state <= BUSY;
            cnt   <= 8'd1;
          end
        end
        BUSY: begin
          if (cnt < LAST_CNT) begin
            cnt <= cnt + 8'd1;
          end else begin
            state <= IDLE;
            cnt   <= 8'd0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 8'd0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Both counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (StallF && StallCnt != CNT_MAX) StallCnt <= StallCnt + CNT_W'(1);
      if (FlushD && FlushCnt != CNT_MAX) FlushCnt <= FlushCnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_mdu.sv
// ---------------------------------------------------------------------------
// tb_hazard_mdu
//   Directed bench for hazard_mdu (REG_AW=5, MDU_LAT=4).
//   A reference model compares every DUT output on each falling edge. The
//   model tracks the MDU occupancy as a countdown of remaining BUSY cycles.
//   Hand-computed literal expectations at the key points pin the model.
// ---------------------------------------------------------------------------
module tb_hazard_mdu;

  localparam int AW  = 5;
  localparam int LAT = 4;
`ifdef HAZARD_PERF_EN
  localparam int CW  = 4;
`else
  localparam int CW  = 32;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] Rs1E, Rs2E, RdM, RdW, Rs1D, Rs2D, RdE;
  logic          RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MulStartE;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          StallF, StallD, StallE, FlushD, FlushE, FlushM, MduBusy;
`ifdef HAZARD_PERF_EN
  logic [CW-1:0] StallCnt, FlushCnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  hazard_mdu #(.REG_AW(AW), .MDU_LAT(LAT), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .MulStartE(MulStartE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .MduBusy(MduBusy)
`ifdef HAZARD_PERF_EN
    , .StallCnt(StallCnt), .FlushCnt(FlushCnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int busy_left = 0;  // BUSY cycles still to run, including the current one
`ifdef HAZARD_PERF_EN
  int m_stall_cnt = 0;
  int m_flush_cnt = 0;
`endif

  function automatic logic [1:0] m_fwd(input logic [AW-1:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  always @(negedge clk) begin
    logic lw, enter, mdu, stall;
    lw    = ResultSrcE0 && RdE != 0 && (Rs1D == RdE || Rs2D == RdE);
    enter = (busy_left == 0) && MulStartE && !PCSrcE;
    mdu   = enter || (busy_left > 1);
    stall = lw || mdu;
    check("m_fwd_a",  32'(ForwardAE), 32'(m_fwd(Rs1E)));
    check("m_fwd_b",  32'(ForwardBE), 32'(m_fwd(Rs2E)));
    check("m_stallf", 32'(StallF),  32'(stall));
    check("m_stalld", 32'(StallD),  32'(stall));
    check("m_stalle", 32'(StallE),  32'(mdu));
    check("m_flushm", 32'(FlushM),  32'(mdu));
    check("m_flushd", 32'(FlushD),  32'(PCSrcE));
    check("m_flushe", 32'(FlushE),  32'(PCSrcE || (lw && !mdu)));
    check("m_busy",   32'(MduBusy), 32'(busy_left > 0));
`ifdef HAZARD_PERF_EN
    check("m_stallcnt", 32'(StallCnt), 32'(m_stall_cnt));
    check("m_flushcnt", 32'(FlushCnt), 32'(m_flush_cnt));
    if (reset) begin
      m_stall_cnt = 0;
      m_flush_cnt = 0;
    end else begin
      if (stall  && m_stall_cnt < (1 << CW) - 1) m_stall_cnt++;
      if (PCSrcE && m_flush_cnt < (1 << CW) - 1) m_flush_cnt++;
    end
`endif
    if (reset)               busy_left = 0;
    else if (busy_left == 0) busy_left = enter ? LAT - 1 : 0;
    else                     busy_left = busy_left - 1;
  end

  // ---------------- stimulus helpers ----------------
  task automatic next_cycle;  // inputs change just after the rising edge
    @(posedge clk); #1;
  endtask

  task automatic probe;       // literal checks sit just after the falling edge
    @(negedge clk); #1;
  endtask

  task automatic clear_inputs;
    {Rs1E, Rs2E, RdM, RdW, Rs1D, Rs2D, RdE} = '0;
    {RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MulStartE} = '0;
  endtask

  task automatic expect_ctl(input string tag, input logic [6:0] exp);
    // order: StallF StallD StallE FlushD FlushE FlushM MduBusy
    check(tag, 32'({StallF, StallD, StallE, FlushD, FlushE, FlushM, MduBusy}), 32'(exp));
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    next_cycle(); next_cycle();
    probe();
    expect_ctl("reset_ctl", 7'b0000000);
    check("reset_fwd", 32'({ForwardAE, ForwardBE}), 32'd0);
    next_cycle();
    reset = 1'b0;

    // Forwarding priority.
    Rs1E = 5; RdM = 5; RdW = 5; RegWriteM = 1; RegWriteW = 1;
    probe(); check("fwd_m_prio", 32'(ForwardAE), 32'd2);
    next_cycle(); RdM = 0;
    probe(); check("fwd_w",      32'(ForwardAE), 32'd1);
    next_cycle(); RdW = 0;
    probe(); check("fwd_none",   32'(ForwardAE), 32'd0);
    next_cycle(); Rs2E = 9; RdW = 9; RdM = 9; RegWriteM = 0;
    probe(); check("fwd_b_w",    32'(ForwardBE), 32'd1);
    next_cycle(); clear_inputs();

    // Load-use.
    ResultSrcE0 = 1; RdE = 7; Rs2D = 7;
    probe(); expect_ctl("lw_hit", 7'b1100100);
    next_cycle(); RdE = 0;
    probe(); expect_ctl("lw_x0", 7'b0000000);
    next_cycle(); clear_inputs();

    // MDU op held for LAT cycles.
    MulStartE = 1;
    probe(); expect_ctl("mdu_c1", 7'b1110010);
    next_cycle();
    probe(); expect_ctl("mdu_c2", 7'b1110011);
    next_cycle();
    probe(); expect_ctl("mdu_c3", 7'b1110011);
    next_cycle();
    probe(); expect_ctl("mdu_c4", 7'b0000001);
    next_cycle(); MulStartE = 0;
    probe(); expect_ctl("mdu_c5", 7'b0000000);
    next_cycle();

    // MDU op with a load-use in D.
    MulStartE = 1;
    next_cycle(); ResultSrcE0 = 1; RdE = 3; Rs1D = 3;
    probe(); expect_ctl("mdu_lw_c2", 7'b1110011);
    next_cycle();
    probe(); expect_ctl("mdu_lw_c3", 7'b1110011);
    next_cycle();
    probe(); expect_ctl("mdu_lw_c4", 7'b1100101);
    next_cycle(); clear_inputs();
    probe(); expect_ctl("mdu_lw_c5", 7'b0000000);
    next_cycle();

    // Branch, and branch together with MulStartE (branch wins).
    PCSrcE = 1;
    probe(); expect_ctl("branch", 7'b0001100);
    next_cycle(); MulStartE = 1;
    probe(); expect_ctl("branch_mul", 7'b0001100);
    next_cycle(); clear_inputs();
    probe(); expect_ctl("branch_mul_after", 7'b0000000);
    next_cycle();

    // Reset in cycle 2 of an MDU op.
    MulStartE = 1;
    next_cycle(); reset = 1;
    probe(); check("rst_mid_busy", 32'(MduBusy), 32'd1);
    next_cycle(); reset = 0; MulStartE = 0;
    probe(); expect_ctl("rst_mid_after", 7'b0000000);
    next_cycle();

`ifdef HAZARD_PERF_EN
    reset = 1;
    next_cycle(); reset = 0;
    probe(); check("perf_cleared", 32'(StallCnt), 32'd0);
    ResultSrcE0 = 1; RdE = 4; Rs1D = 4;
    for (int i = 0; i < 20; i++) next_cycle();
    clear_inputs();
    probe(); check("perf_sat", 32'(StallCnt), 32'd15);
    next_cycle(); reset = 1;
    next_cycle(); reset = 0;
    probe(); check("perf_reset", 32'(StallCnt), 32'd0);
    next_cycle();
`endif

    probe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Safety bound so the run always ends on its own.
  initial begin
    #100000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
